// File: rtl/sbi_mem_banked.sv
// sbi_mem_banked: SBI burst slave over a bank-interleaved single-port RAM.
// Burst address counter, optional wrap window, read latency 1 + OutReg.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   bADDR            burst start word address, used when bSTART=1
//   bSTART           load burst address (preload when bACCESS=0)
//   bACCESS, bWRITE  beat valid / beat direction (1 = write)
//   bD               write data
//   bQ, bVALID       read data and its one-cycle valid strobe
//   bERR             parity error, aligned with bVALID (SBI_MEM_PARITY_EN only)
//
// Optional feature macro: SBI_MEM_PARITY_EN (one even-parity bit per word).

module sbi_mem_banked #(
    parameter int Width   = 32,
    parameter int Depth   = 256,
    parameter int Banks   = 4,
    parameter int WrapLen = 0,
    parameter int OutReg  = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [$clog2(Depth)-1:0] bADDR,
    input  logic                     bSTART,
    input  logic                     bACCESS,
    input  logic                     bWRITE,
    input  logic [Width-1:0]         bD,
    output logic [Width-1:0]         bQ,
`ifdef SBI_MEM_PARITY_EN
    output logic                     bVALID,
    output logic                     bERR
`else
    output logic                     bVALID
`endif
);

    localparam int Aw   = $clog2(Depth);
    localparam int Lb   = $clog2(Banks);
    localparam int Bw   = (Lb > 0) ? Lb : 1;
    localparam int Rw   = (Aw > Lb) ? Aw - Lb : 1;
    localparam int Rows = 1 << Rw;
`ifdef SBI_MEM_PARITY_EN
    localparam int Dw   = Width + 1;
`else
    localparam int Dw   = Width;
`endif

    // Bits of the address that advance within a burst; the rest stay fixed.
    localparam logic [Aw-1:0] WMask =
        (WrapLen == 0) ? {Aw{1'b1}} : Aw'(WrapLen - 1);

    logic [Aw-1:0]       r_cnt;
    logic [Aw-1:0]       w_addr;
    logic [Aw-1:0]       w_next;
    logic [Bw-1:0]       w_bank;
    logic [Bw-1:0]       r_sel;
    logic [Rw-1:0]       w_row;
    logic                w_rd_beat;
    logic                r_v1;
    logic [Dw-1:0]       w_wword;
    logic [Dw-1:0]       w_word1;
    logic [Banks*Dw-1:0] w_rd_flat;

    assign w_addr    = bSTART ? bADDR : r_cnt;
    assign w_next    = (w_addr & ~WMask) | ((w_addr + Aw'(1)) & WMask);
    assign w_bank    = Bw'(w_addr) & Bw'(Banks - 1);
    assign w_row     = Rw'(w_addr >> Lb);
    assign w_rd_beat = bACCESS & ~bWRITE;

`ifdef SBI_MEM_PARITY_EN
    assign w_wword = {^bD, bD};
`else
    assign w_wword = bD;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_v1  <= 1'b0;
            r_sel <= '0;
        end else begin
            if (bACCESS) begin
                r_cnt <= w_next;
            end else if (bSTART) begin
                r_cnt <= bADDR;
            end
            r_v1 <= w_rd_beat;
            if (w_rd_beat) begin
                r_sel <= w_bank;
            end
        end
    end

    for (genvar b = 0; b < Banks; b++) begin : g_bank
        logic [Dw-1:0] r_mem [Rows];
        logic [Dw-1:0] r_rd;
        logic          w_en;

        assign w_en = bACCESS && (w_bank == Bw'(b));

        always_ff @(posedge clk_i) begin
            if (w_en && bWRITE) begin
                r_mem[w_row] <= w_wword;
            end
        end

        // Read register holds its word until this bank is read again,
        // so the selected bank always shows the most recent read.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rd <= '0;
            end else if (w_en && !bWRITE) begin
                r_rd <= r_mem[w_row];
            end
        end

        assign w_rd_flat[b*Dw +: Dw] = r_rd;
    end

    always_comb begin
        w_word1 = '0;
        for (int b = 0; b < Banks; b++) begin
            if (r_sel == Bw'(b)) begin
                w_word1 = w_rd_flat[b*Dw +: Dw];
            end
        end
    end

    if (OutReg != 0) begin : g_oreg
        logic             r_v2;
        logic [Width-1:0] r_q2;
`ifdef SBI_MEM_PARITY_EN
        logic             r_e2;
`endif

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_v2 <= 1'b0;
                r_q2 <= '0;
`ifdef SBI_MEM_PARITY_EN
                r_e2 <= 1'b0;
`endif
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_q2 <= w_word1[Width-1:0];
`ifdef SBI_MEM_PARITY_EN
                    r_e2 <= ^w_word1;
`endif
                end
            end
        end

        assign bVALID = r_v2;
        assign bQ     = r_q2;
`ifdef SBI_MEM_PARITY_EN
        assign bERR   = r_v2 & r_e2;
`endif
    end else begin : g_noreg
        assign bVALID = r_v1;
        assign bQ     = w_word1[Width-1:0];
`ifdef SBI_MEM_PARITY_EN
        // Stored parity makes the whole word's XOR zero when clean.
        assign bERR   = r_v1 & (^w_word1);
`endif
    end

endmodule

// File: tb/tb_sbi_mem_banked.sv
// tb_sbi_mem_banked: three sbi_mem_banked configurations on one shared bus
// (default, WrapLen=4, OutReg=1) checked against a flat-memory model.

module tb_sbi_mem_banked;

    typedef struct {
        int          due;
        bit          known;
        logic [31:0] d;
        bit          bad;
    } exp_t;

    typedef struct {
        int          c;
        logic [31:0] d;
        bit          e;
    } lg_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  bADDR;
    logic        bSTART;
    logic        bACCESS;
    logic        bWRITE;
    logic [31:0] bD;
    logic [31:0] q_o [3];
    logic        v_o [3];
`ifdef SBI_MEM_PARITY_EN
    logic        e_o [3];
`endif

    int          cyc;
    int          nchk;
    int          nerr;
    int          LAT  [3] = '{1, 1, 2};
    int          WRAP [3] = '{0, 4, 0};
    logic [31:0] mmem [3][256];
    bit          mkn  [3][256];
    bit          flip [256];
    int          mcnt [3];
    exp_t        q    [3][$];
    lg_t         lg   [3][$];
    logic [31:0] last [3];
    bit          lastk[3];
    int          tr;

    sbi_mem_banked u_a (
        .clk_i(clk), .rst_ni(rst_n), .bADDR(bADDR), .bSTART(bSTART),
        .bACCESS(bACCESS), .bWRITE(bWRITE), .bD(bD), .bQ(q_o[0]),
`ifdef SBI_MEM_PARITY_EN
        .bVALID(v_o[0]), .bERR(e_o[0])
`else
        .bVALID(v_o[0])
`endif
    );

    sbi_mem_banked #(.WrapLen(4)) u_w (
        .clk_i(clk), .rst_ni(rst_n), .bADDR(bADDR), .bSTART(bSTART),
        .bACCESS(bACCESS), .bWRITE(bWRITE), .bD(bD), .bQ(q_o[1]),
`ifdef SBI_MEM_PARITY_EN
        .bVALID(v_o[1]), .bERR(e_o[1])
`else
        .bVALID(v_o[1])
`endif
    );

    sbi_mem_banked #(.OutReg(1)) u_o (
        .clk_i(clk), .rst_ni(rst_n), .bADDR(bADDR), .bSTART(bSTART),
        .bACCESS(bACCESS), .bWRITE(bWRITE), .bD(bD), .bQ(q_o[2]),
`ifdef SBI_MEM_PARITY_EN
        .bVALID(v_o[2]), .bERR(e_o[2])
`else
        .bVALID(v_o[2])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nxt(input int a, input int w);
        if (w == 0) return (a + 1) % 256;
        return (a / w) * w + ((a % w) + 1) % w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int   a;
        exp_t e;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                q[i].delete();
                mcnt[i] = 0;
                continue;
            end
            a = bSTART ? int'(bADDR) : mcnt[i];
            if (bACCESS) begin
                if (bWRITE) begin
                    mmem[i][a] = bD;
                    mkn[i][a]  = 1'b1;
                end else begin
                    e.due   = cyc + LAT[i] - 1;
                    e.known = mkn[i][a];
                    e.bad   = (i == 0) && flip[a];
                    e.d     = mmem[i][a] ^ (e.bad ? 32'h1 : 32'h0);
                    q[i].push_back(e);
                end
                mcnt[i] = nxt(a, WRAP[i]);
            end else if (bSTART) begin
                mcnt[i] = int'(bADDR);
            end
        end
    endtask

    task automatic cmp_step();
        exp_t e;
        bit   ev;
        lg_t  l;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk($sformatf("rst_valid%0d", i), 32'(v_o[i]), 32'h0);
                chk($sformatf("rst_q%0d", i), q_o[i], 32'h0);
                last[i]  = 32'h0;
                lastk[i] = 1'b1;
                continue;
            end
            while (q[i].size() > 0 && q[i][0].due < cyc)
                void'(q[i].pop_front());
            ev = (q[i].size() > 0) && (q[i][0].due == cyc);
            chk($sformatf("valid%0d", i), 32'(v_o[i]), 32'(ev));
            if (ev && v_o[i] === 1'b1) begin
                e = q[i].pop_front();
                if (e.known) chk($sformatf("q%0d", i), q_o[i], e.d);
                last[i]  = e.d;
                lastk[i] = e.known;
                l.c = cyc;
                l.d = q_o[i];
                l.e = 1'b0;
`ifdef SBI_MEM_PARITY_EN
                chk($sformatf("err%0d", i), 32'(e_o[i]), 32'(e.bad));
                l.e = e_o[i];
`endif
                lg[i].push_back(l);
            end else begin
                if (ev) void'(q[i].pop_front());
                if (lastk[i]) chk($sformatf("hold%0d", i), q_o[i], last[i]);
`ifdef SBI_MEM_PARITY_EN
                chk($sformatf("err_idle%0d", i), 32'(e_o[i]), 32'h0);
`endif
            end
        end
    endtask

    task automatic bt(input logic st, input logic [7:0] a, input logic acc,
                      input logic wr, input logic [31:0] d);
        bSTART  = st;
        bADDR   = a;
        bACCESS = acc;
        bWRITE  = wr;
        bD      = d;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) bt(1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wr_burst(input logic [7:0] a, input logic [31:0] d [4]);
        bt(1'b1, a, 1'b1, 1'b1, d[0]);
        for (int k = 1; k < 4; k++) bt(1'b0, 8'h0, 1'b1, 1'b1, d[k]);
    endtask

    task automatic rd_burst(input logic [7:0] a, input int n, output int t);
        bt(1'b1, a, 1'b1, 1'b0, 32'h0);
        t = cyc;
        for (int k = 1; k < n; k++) bt(1'b0, 8'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) lg[i].delete();
    endtask

    task automatic expect_seq(input int i, input string nm, input int c0,
                              input int n, input logic [31:0] ex [4]);
        chk({nm, "_count"}, 32'(lg[i].size()), 32'(n));
        for (int k = 0; k < n && k < lg[i].size(); k++) begin
            chk($sformatf("%s_d%0d", nm, k), lg[i][k].d, ex[k]);
            chk($sformatf("%s_c%0d", nm, k), 32'(lg[i][k].c), 32'(c0 + k));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bSTART  = 1'b0;
        bADDR   = 8'h0;
        bACCESS = 1'b0;
        bWRITE  = 1'b0;
        bD      = 32'h0;
        fork
            forever begin @(posedge clk); model_step(); end
            forever begin @(negedge clk); cmp_step(); end
        join_none
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        wr_burst(8'h04, '{32'h4, 32'h5, 32'h6, 32'h7});
        wr_burst(8'h08, '{32'h8, 32'h9, 32'hA, 32'hB});
        bt(1'b1, 8'h21, 1'b1, 1'b1, 32'h2121);
        bt(1'b1, 8'h30, 1'b1, 1'b1, 32'h3030);
        idle(1);

        wr_burst(8'h10, '{32'hA0, 32'hA1, 32'hA2, 32'hA3});
        idle(1);
        clr();
        rd_burst(8'h10, 4, tr);
        idle(3);
        expect_seq(0, "t1_a", tr, 4, '{32'hA0, 32'hA1, 32'hA2, 32'hA3});
        expect_seq(2, "t1_o", tr + 1, 4, '{32'hA0, 32'hA1, 32'hA2, 32'hA3});

        bt(1'b1, 8'hFE, 1'b1, 1'b1, 32'h1);
        bt(1'b0, 8'h00, 1'b1, 1'b1, 32'h2);
        bt(1'b0, 8'h00, 1'b1, 1'b1, 32'h3);
        idle(1);
        clr();
        rd_burst(8'hFE, 3, tr);
        idle(3);
        expect_seq(0, "t2_a", tr, 3, '{32'h1, 32'h2, 32'h3, 32'h0});
        expect_seq(1, "t2_w", tr, 3, '{32'h1, 32'h2, 32'h3, 32'h0});

        clr();
        rd_burst(8'h06, 4, tr);
        idle(3);
        expect_seq(1, "t3_w", tr, 4, '{32'h6, 32'h7, 32'h4, 32'h5});
        expect_seq(0, "t3_a", tr, 4, '{32'h6, 32'h7, 32'h8, 32'h9});

        clr();
        rd_burst(8'h10, 1, tr);
        idle(1);
        chk("t4_v", 32'(v_o[2]), 32'h1);
        chk("t4_q", q_o[2], 32'hA0);
        idle(1);
        chk("t4_v_after", 32'(v_o[2]), 32'h0);
        chk("t4_hold", q_o[2], 32'hA0);
        idle(1);
        expect_seq(2, "t4_o", tr + 1, 1, '{32'hA0, 32'h0, 32'h0, 32'h0});

        clr();
        bt(1'b1, 8'h20, 1'b1, 1'b1, 32'h55);
        bt(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        tr = cyc;
        bt(1'b1, 8'h20, 1'b1, 1'b0, 32'h0);
        idle(3);
        expect_seq(0, "t5_a", tr, 2, '{32'h2121, 32'h55, 32'h0, 32'h0});
        expect_seq(2, "t5_o", tr + 1, 2, '{32'h2121, 32'h55, 32'h0, 32'h0});
        clr();
        bt(1'b1, 8'h30, 1'b0, 1'b0, 32'h0);
        bt(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        tr = cyc;
        idle(3);
        expect_seq(0, "t5_pre_a", tr, 1, '{32'h3030, 32'h0, 32'h0, 32'h0});
        expect_seq(1, "t5_pre_w", tr, 1, '{32'h3030, 32'h0, 32'h0, 32'h0});

        bt(1'b1, 8'h10, 1'b1, 1'b0, 32'h0);
        bt(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        clr();
        idle(2);
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_cnt%0d", i), 32'(lg[i].size()), 32'h0);
            chk($sformatf("t6_q%0d", i), q_o[i], 32'h0);
        end

`ifdef SBI_MEM_PARITY_EN
        u_a.g_bank[1].r_mem[4][0] = ~u_a.g_bank[1].r_mem[4][0];
        flip[8'h11] = 1'b1;
`endif
        clr();
        rd_burst(8'h10, 2, tr);
        idle(3);
`ifdef SBI_MEM_PARITY_EN
        expect_seq(0, "t6_ram", tr, 2, '{32'hA0, 32'hA0, 32'h0, 32'h0});
        if (lg[0].size() == 2) begin
            chk("t6_err_clean", 32'(lg[0][0].e), 32'h0);
            chk("t6_err_flip", 32'(lg[0][1].e), 32'h1);
        end else begin
            chk("t6_err_log", 32'(lg[0].size()), 32'h2);
        end
`else
        expect_seq(0, "t6_ram", tr, 2, '{32'hA0, 32'hA1, 32'h0, 32'h0});
`endif
        expect_seq(2, "t6_ram_o", tr + 1, 2, '{32'hA0, 32'hA1, 32'h0, 32'h0});

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
